// File: rtl/line_fill_demux.sv
// line_fill_demux: cache refill write path. Collects a 4-word wrapping burst
// (critical word first) into a line register. It forwards the critical word
// early and hands the finished line to the cache array under valid/ack.
module line_fill_demux #(
   parameter int BUS_WIDTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [1:0]             i_start_offset,
   input  logic                   i_word_valid,
   input  logic [BUS_WIDTH-1:0]   i_word_data,
   output logic                   o_word_ready,
   output logic [4*BUS_WIDTH-1:0] o_line_data,
   output logic [3:0]             o_word_mask,
   output logic                   o_line_valid,
   input  logic                   i_line_ack,
   output logic                   o_crit_valid,
   output logic [BUS_WIDTH-1:0]   o_crit_data,
   output logic                   o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] ptr;
   logic [1:0] count;
   logic       beat;

   // Ready is decoded from state alone, so there is no path from i_word_valid.
   assign o_word_ready = (state == FILL);
   assign o_busy       = (state != IDLE);
   assign beat         = (state == FILL) && i_word_valid;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start only in IDLE, four beats in FILL, ack only in DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_start) state_next = FILL;
         FILL:    if (beat && (count == 2'd3)) state_next = DONE;
         DONE:    if (i_line_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Fill bookkeeping: slot pointer, beat count, mask, critical word, line valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr          <= 2'd0;
         count        <= 2'd0;
         o_word_mask  <= 4'd0;
         o_crit_valid <= 1'b0;
         o_crit_data  <= '0;
         o_line_valid <= 1'b0;
      end else begin
         o_crit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  ptr         <= i_start_offset;
                  count       <= 2'd0;
                  o_word_mask <= 4'd0;
               end
            end
            FILL: begin
               if (beat) begin
                  ptr              <= ptr + 2'd1;
                  count            <= count + 2'd1;
                  o_word_mask[ptr] <= 1'b1;
                  if (count == 2'd0) begin
                     o_crit_data  <= i_word_data;
                     o_crit_valid <= 1'b1;
                  end
                  if (count == 2'd3) begin
                     o_line_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (i_line_ack) begin
                  o_line_valid <= 1'b0;
               end
            end
            default: begin
               o_line_valid <= 1'b0;
            end
         endcase
      end
   end

   // One register per word slot; a beat writes only the slot ptr points at.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
         logic [BUS_WIDTH-1:0] slot;

         // Capture the incoming word when this slot is the current target.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               slot <= '0;
            end else if (beat && (ptr == 2'(gi))) begin
               slot <= i_word_data;
            end
         end

         assign o_line_data[gi*BUS_WIDTH +: BUS_WIDTH] = slot;
      end
   endgenerate

endmodule

// File: tb/tb_line_fill_demux.sv
// Testbench for line_fill_demux. It applies a table of refill bursts with
// hand-computed line images, then runs directed sequences for the handshake,
// mid-fill reset and start/ack collision cases.
module tb_line_fill_demux;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [1:0]   start_offset;
   logic         word_valid;
   logic [31:0]  word_data;
   logic         word_ready;
   logic [127:0] line_data;
   logic [3:0]   word_mask;
   logic         line_valid;
   logic         line_ack;
   logic         crit_valid;
   logic [31:0]  crit_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   line_fill_demux #(.BUS_WIDTH(32)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_start_offset (start_offset),
      .i_word_valid   (word_valid),
      .i_word_data    (word_data),
      .o_word_ready   (word_ready),
      .o_line_data    (line_data),
      .o_word_mask    (word_mask),
      .o_line_valid   (line_valid),
      .i_line_ack     (line_ack),
      .o_crit_valid   (crit_valid),
      .o_crit_data    (crit_data),
      .o_busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the whole run is a few hundred cycles.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [1:0]        off;
      logic [3:0][31:0]  w;     // w[0] is delivered first
      int                gap;   // idle cycles before each beat after the first
      logic [127:0]      line;  // expected line, slot 3 in the top word
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Runs one refill starting at a negedge; leaves the DUT in DONE at a negedge.
   task automatic do_fill(input logic [1:0] off, input logic [3:0][31:0] w,
                          input int gap, input logic [127:0] exp_line);
      logic [3:0] exp_mask;
      exp_mask     = 4'd0;
      start        = 1'b1;
      start_offset = off;
      @(negedge clk);
      start = 1'b0;
      chk("fill_busy", 128'(busy), 128'(1'b1));
      chk("fill_ready", 128'(word_ready), 128'(1'b1));
      chk("fill_mask_clear", 128'(word_mask), 128'(4'd0));
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               word_valid = 1'b0;
               word_data  = 32'hBAD0_0000 | 32'(g);
               @(negedge clk);
               chk("stall_ready", 128'(word_ready), 128'(1'b1));
               chk("stall_mask", 128'(word_mask), 128'(exp_mask));
               chk("stall_crit_valid", 128'(crit_valid), 128'(1'b0));
               chk("stall_line_valid", 128'(line_valid), 128'(1'b0));
            end
         end
         word_valid = 1'b1;
         word_data  = w[k];
         @(negedge clk);
         exp_mask = exp_mask | (4'b0001 << ((off + 2'(k)) & 2'd3));
         chk("beat_mask", 128'(word_mask), 128'(exp_mask));
         chk("beat_crit_valid", 128'(crit_valid), 128'(k == 0));
         if (k == 0) chk("beat_crit_data", 128'(crit_data), 128'(w[0]));
         chk("beat_line_valid", 128'(line_valid), 128'(k == 3));
         chk("beat_ready", 128'(word_ready), 128'(k != 3));
      end
      word_valid = 1'b0;
      word_data  = 32'h0;
      chk("fill_line", line_data, exp_line);
      chk("fill_crit_data", 128'(crit_data), 128'(w[0]));
      chk("fill_busy_done", 128'(busy), 128'(1'b1));
   endtask

   // Acknowledge the line and confirm return to IDLE with data retained.
   task automatic do_ack(input logic [127:0] exp_line);
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;
      chk("ack_line_valid", 128'(line_valid), 128'(1'b0));
      chk("ack_busy", 128'(busy), 128'(1'b0));
      chk("ack_line_kept", line_data, exp_line);
      chk("ack_mask_kept", 128'(word_mask), 128'(4'hF));
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      start_offset = 2'd0;
      word_valid   = 1'b0;
      word_data    = 32'h0;
      line_ack     = 1'b0;

      vecs[0] = '{off: 2'd0, w: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, gap: 0,
                  line: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
      vecs[1] = '{off: 2'd2, w: {32'hB3, 32'hB2, 32'hB1, 32'hB0}, gap: 0,
                  line: {32'hB1, 32'hB0, 32'hB3, 32'hB2}};
      vecs[2] = '{off: 2'd3, w: {32'hC3, 32'hC2, 32'hC1, 32'hC0}, gap: 2,
                  line: {32'hC0, 32'hC3, 32'hC2, 32'hC1}};
      vecs[3] = '{off: 2'd1, w: {32'hD3, 32'hD2, 32'hD1, 32'hD0}, gap: 1,
                  line: {32'hD2, 32'hD1, 32'hD0, 32'hD3}};

      // Reset state.
      @(negedge clk);
      chk("rst_line", line_data, 128'd0);
      chk("rst_mask", 128'(word_mask), 128'(4'd0));
      chk("rst_flags", 128'({line_valid, crit_valid, word_ready, busy}), 128'(4'd0));
      chk("rst_crit", 128'(crit_data), 128'(32'd0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 128'(word_ready), 128'(1'b0));
      $display("reset: checks=%0d errors=%0d", checks, errors);

      // Table-driven fills.
      for (int v = 0; v < 4; v++) begin
         do_fill(vecs[v].off, vecs[v].w, vecs[v].gap, vecs[v].line);
         do_ack(vecs[v].line);
         $display("vector %0d off=%0d gap=%0d line=%h errors=%0d",
                  v, vecs[v].off, vecs[v].gap, line_data, errors);
      end

      // Handshake boundaries: DONE held 5 cycles with start/valid pulses.
      do_fill(2'd0, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
      for (int i = 0; i < 5; i++) begin
         start      = (i % 2) == 1;
         word_valid = 1'b1;
         word_data  = 32'hDEAD_0000 | 32'(i);
         @(negedge clk);
         chk("hold_line_valid", 128'(line_valid), 128'(1'b1));
         chk("hold_busy", 128'(busy), 128'(1'b1));
         chk("hold_ready", 128'(word_ready), 128'(1'b0));
         chk("hold_line", line_data, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
         chk("hold_mask", 128'(word_mask), 128'(4'hF));
         chk("hold_crit_valid", 128'(crit_valid), 128'(1'b0));
      end
      start      = 1'b0;
      word_valid = 1'b0;
      do_ack({32'hF3, 32'hF2, 32'hF1, 32'hF0});
      chk("ack_crit_kept", 128'(crit_data), 128'(32'hF0));
      start        = 1'b1;
      start_offset = 2'd0;
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", 128'(busy), 128'(1'b1));
      chk("restart_ready", 128'(word_ready), 128'(1'b1));
      $display("handshake hold: errors=%0d", errors);

      // Reset mid-fill after two beats.
      word_valid = 1'b1;
      word_data  = 32'h11;
      @(negedge clk);
      word_data  = 32'h22;
      @(negedge clk);
      word_valid = 1'b0;
      chk("partial_mask", 128'(word_mask), 128'(4'b0011));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_line", line_data, 128'd0);
      chk("arst_mask", 128'(word_mask), 128'(4'd0));
      chk("arst_flags", 128'({line_valid, crit_valid, word_ready, busy}), 128'(4'd0));
      chk("arst_crit", 128'(crit_data), 128'(32'd0));
      @(negedge clk);
      rst_n = 1'b1;
      do_fill(2'd1, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0, {32'hE2, 32'hE1, 32'hE0, 32'hE3});
      do_ack({32'hE2, 32'hE1, 32'hE0, 32'hE3});
      $display("reset mid-fill: errors=%0d", errors);

      // Start/ack collision in DONE: start must be ignored.
      do_fill(2'd0, {32'h93, 32'h92, 32'h91, 32'h90}, 0, {32'h93, 32'h92, 32'h91, 32'h90});
      start    = 1'b1;
      line_ack = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      line_ack = 1'b0;
      chk("coll_busy", 128'(busy), 128'(1'b0));
      chk("coll_line_valid", 128'(line_valid), 128'(1'b0));
      @(negedge clk);
      chk("coll_no_start", 128'(busy), 128'(1'b0));
      chk("coll_no_ready", 128'(word_ready), 128'(1'b0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("coll_restart", 128'(busy), 128'(1'b1));
      chk("coll_mask_clear", 128'(word_mask), 128'(4'd0));
      $display("start/ack collision: errors=%0d", errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
